// File: rtl/puzzle_pkg.sv
// Shared definitions for the colour-cycling puzzle grid engine.
// Contents: FSM state type, LFSR width and tap mask, default grid geometry
// and the helper that maps a (row, col) cell to its slot in the packed grid.
package puzzle_pkg;

    typedef enum logic {
        IDLE     = 1'b0,
        SCRAMBLE = 1'b1
    } fsm_state_t;

    // 16-bit Fibonacci LFSR, taps 16,14,13,11 (bits 15,13,12,10), shifting left.
    localparam int              LFSR_W    = 16;
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

    localparam int DEF_ROWS    = 4;
    localparam int DEF_COLS    = 4;
    localparam int DEF_STATE_W = 2;

    // Linear cell slot used for packing grid_state.
    function automatic int cell_idx(input int r, input int c, input int cols);
        return r * cols + c;
    endfunction

endpackage

// File: rtl/puzzle_lfsr.sv
// Seeded 16-bit Fibonacci LFSR.
// Ports:
//   clk     in   system clock
//   reload  in   load SEED on the next clock edge (has priority over enable)
//   enable  in   advance one step on the next clock edge
//   value   out  low OUT_W bits of the current LFSR state
module puzzle_lfsr
    import puzzle_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED  = 16'hACE1,
    parameter int                OUT_W = 4
) (
    input  logic             clk,
    input  logic             reload,
    input  logic             enable,
    output logic [OUT_W-1:0] value
);

    logic [LFSR_W-1:0] lfsr;

    always_ff @(posedge clk) begin
        if (reload) begin
            lfsr <= SEED;
        end else if (enable) begin
            lfsr <= {lfsr[LFSR_W-2:0], ^(lfsr & LFSR_TAPS)};
        end
    end

    assign value = lfsr[OUT_W-1:0];

endmodule

// File: rtl/puzzle_grid_engine.sv
// ROWS x COLS cell-state engine for the colour-cycling puzzle.
// A validated row/column fire steps every cell of the selected line by +1/-1
// modulo 2^STATE_W. A scrambler applies SCRAMBLE_N random LFSR-driven moves,
// a saturating counter tracks user moves and a registered flag reports solved.
// Ports:
//   clk, reset (sync, active-low)
//   fire, sel_col, sel[SEL_W], dir_dec   user move request
//   scramble_start                       start a scramble
//   grid_state  packed cells, (r,c) at [(r*COLS+c)*STATE_W +: STATE_W]
//   solved      all cells equal (one cycle behind the grid, 0 while busy)
//   busy        scramble in progress
//   move_done   pulse per accepted user move
//   sel_error   registered select-invalid flag
//   move_count  saturating count of accepted user moves
module puzzle_grid_engine
    import puzzle_pkg::*;
#(
    parameter int                ROWS       = DEF_ROWS,
    parameter int                COLS       = DEF_COLS,
    parameter int                STATE_W    = DEF_STATE_W,
    parameter int                SCRAMBLE_N = 16,
    parameter int                CNT_W      = 14,
    parameter logic [LFSR_W-1:0] LFSR_SEED  = 16'hACE1,
    localparam int               SEL_W      = (ROWS > COLS) ? ROWS : COLS
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          fire,
    input  logic                          sel_col,
    input  logic [SEL_W-1:0]              sel,
    input  logic                          dir_dec,
    input  logic                          scramble_start,
    output logic [ROWS*COLS*STATE_W-1:0]  grid_state,
    output logic                          solved,
    output logic                          busy,
    output logic                          move_done,
    output logic                          sel_error,
    output logic [CNT_W-1:0]              move_count
);

    localparam int IDX_W = 3;
    localparam int LIM_W = IDX_W + 1;
    localparam int SCR_W = $clog2(SCRAMBLE_N + 1);
    localparam logic [LIM_W-1:0] ROWS_L = LIM_W'(ROWS);
    localparam logic [LIM_W-1:0] COLS_L = LIM_W'(COLS);

    function automatic logic is_onehot(input logic [SEL_W-1:0] v);
        return (v != '0) && ((v & (v - SEL_W'(1))) == '0);
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

    fsm_state_t        state;
    logic [SCR_W-1:0]  scr_cnt;
    logic [IDX_W:0]    lfsr_bits;

    logic [IDX_W-1:0]  sel_idx;
    logic              sel_valid;
    logic              scr_col;
    logic [IDX_W-1:0]  scr_idx;
    logic              scr_ok;

    logic              mv_en;
    logic              mv_col;
    logic [IDX_W-1:0]  mv_idx;
    logic              mv_dec;
    logic              all_eq;

    // LFSR runs every cycle; reset reloads the seed.
    puzzle_lfsr #(
        .SEED  (LFSR_SEED),
        .OUT_W (IDX_W + 1)
    ) u_lfsr (
        .clk    (clk),
        .reload (!reset),
        .enable (1'b1),
        .value  (lfsr_bits)
    );

    always_comb begin
        sel_idx = '0;
        for (int i = 0; i < SEL_W; i++) begin
            if (sel[i]) sel_idx = IDX_W'(i);
        end
        sel_valid = is_onehot(sel) && ({1'b0, sel_idx} < (sel_col ? COLS_L : ROWS_L));
    end

    // Scramble candidate: bit0 picks row/column, bits[3:1] the line index.
    assign scr_col = lfsr_bits[0];
    assign scr_idx = lfsr_bits[IDX_W:1];
    assign scr_ok  = {1'b0, scr_idx} < (scr_col ? COLS_L : ROWS_L);

    // One line-move decode shared by user and scramble moves, so a row and
    // a column move can never land in the same cycle.
    always_comb begin
        mv_en  = 1'b0;
        mv_col = 1'b0;
        mv_idx = '0;
        mv_dec = 1'b0;
        if (state == IDLE) begin
            if (fire && sel_valid && !scramble_start) begin
                mv_en  = 1'b1;
                mv_col = sel_col;
                mv_idx = sel_idx;
                mv_dec = dir_dec;
            end
        end else if (scr_ok) begin
            mv_en  = 1'b1;
            mv_col = scr_col;
            mv_idx = scr_idx;
        end
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c < COLS; c++) begin : g_col
            logic [STATE_W-1:0] q;
            logic               hit;

            assign hit = mv_en && (mv_col ? (mv_idx == IDX_W'(c)) : (mv_idx == IDX_W'(r)));

            always_ff @(posedge clk) begin
                if (!reset) begin
                    q <= '0;
                end else if (hit) begin
                    q <= mv_dec ? q - STATE_W'(1) : q + STATE_W'(1);
                end
            end

            assign grid_state[cell_idx(r, c, COLS)*STATE_W +: STATE_W] = q;
        end
    end

    always_comb begin
        all_eq = 1'b1;
        for (int i = 1; i < ROWS*COLS; i++) begin
            if (grid_state[i*STATE_W +: STATE_W] != grid_state[STATE_W-1:0]) all_eq = 1'b0;
        end
    end

    // Control FSM with registered outputs. solved samples the current grid,
    // so it trails a move by one cycle, and is held low while scrambling.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            busy       <= 1'b0;
            move_done  <= 1'b0;
            sel_error  <= 1'b0;
            move_count <= '0;
            scr_cnt    <= '0;
            solved     <= 1'b1;
        end else begin
            sel_error <= !sel_valid;
            move_done <= 1'b0;
            solved    <= all_eq;
            case (state)
                IDLE: begin
                    if (scramble_start) begin
                        state   <= SCRAMBLE;
                        busy    <= 1'b1;
                        scr_cnt <= '0;
                        solved  <= 1'b0;
                    end else if (fire && sel_valid) begin
                        move_done  <= 1'b1;
                        move_count <= sat_inc(move_count);
                    end
                end
                SCRAMBLE: begin
                    solved <= 1'b0;
                    if (scr_ok) begin
                        if (scr_cnt == SCR_W'(SCRAMBLE_N - 1)) begin
                            state      <= IDLE;
                            busy       <= 1'b0;
                            move_count <= '0;
                            scr_cnt    <= '0;
                            solved     <= all_eq;
                        end else begin
                            scr_cnt <= scr_cnt + SCR_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_puzzle_grid_engine.sv
// Bench for puzzle_grid_engine: directed stimulus, an array-based model of
// the puzzle rules compared against the DUT every cycle, plus literal checks.
module tb_puzzle_grid_engine;

    localparam int ROWS       = 4;
    localparam int COLS       = 4;
    localparam int STATE_W    = 2;
    localparam int SCRAMBLE_N = 16;
    localparam int CNT_W      = 14;
    localparam int SEL_W      = 4;
    localparam int GW         = ROWS * COLS * STATE_W;
    localparam int MOD        = 1 << STATE_W;
    localparam int CNT_MAX    = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             fire = 1'b0;
    logic             sel_col = 1'b0;
    logic [SEL_W-1:0] sel = '0;
    logic             dir_dec = 1'b0;
    logic             scramble_start = 1'b0;
    logic [GW-1:0]    grid_state;
    logic             solved;
    logic             busy;
    logic             move_done;
    logic             sel_error;
    logic [CNT_W-1:0] move_count;

    always #5 clk = ~clk;

    puzzle_grid_engine #(
        .ROWS       (ROWS),
        .COLS       (COLS),
        .STATE_W    (STATE_W),
        .SCRAMBLE_N (SCRAMBLE_N),
        .CNT_W      (CNT_W),
        .LFSR_SEED  (16'hACE1)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .fire           (fire),
        .sel_col        (sel_col),
        .sel            (sel),
        .dir_dec        (dir_dec),
        .scramble_start (scramble_start),
        .grid_state     (grid_state),
        .solved         (solved),
        .busy           (busy),
        .move_done      (move_done),
        .sel_error      (sel_error),
        .move_count     (move_count)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_grid [ROWS][COLS];
    int m_lfsr;
    int m_cnt;
    int m_acc;
    bit m_busy, m_md, m_se, m_solved;
    bit check_en = 1'b0;

    function automatic int lfsr_step(input int x);
        int fb;
        fb = ((x >> 15) ^ (x >> 13) ^ (x >> 12) ^ (x >> 10)) & 1;
        return ((x << 1) | fb) & 'hFFFF;
    endfunction

    function automatic bit m_all_eq();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                if (m_grid[r][c] != m_grid[0][0]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [GW-1:0] m_pack();
        logic [GW-1:0] v;
        v = '0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                v[(r*COLS+c)*STATE_W +: STATE_W] = STATE_W'(m_grid[r][c]);
        return v;
    endfunction

    function automatic bit sel_ok(input logic [SEL_W-1:0] s, input logic sc);
        int idx;
        if ($countones(s) != 1) return 1'b0;
        idx = $clog2(s);
        return idx < (sc ? COLS : ROWS);
    endfunction

    task automatic m_apply(input bit col, input int idx, input bit dec);
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                if ((col && c == idx) || (!col && r == idx))
                    m_grid[r][c] = (m_grid[r][c] + (dec ? MOD - 1 : 1)) % MOD;
    endtask

    always @(posedge clk) begin : model
        bit eq_before;
        int cur;
        bit col;
        int idx;
        if (!reset) begin
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++)
                    m_grid[r][c] = 0;
            m_lfsr = 'hACE1;
            m_busy = 0; m_md = 0; m_se = 0; m_solved = 1;
            m_cnt = 0; m_acc = 0;
        end else begin
            eq_before = m_all_eq();
            cur  = m_lfsr;
            m_se = !sel_ok(sel, sel_col);
            m_md = 0;
            if (!m_busy) begin
                if (scramble_start) begin
                    m_busy = 1;
                    m_acc  = 0;
                end else if (fire && sel_ok(sel, sel_col)) begin
                    m_apply(sel_col, $clog2(sel), dir_dec);
                    m_md = 1;
                    if (m_cnt < CNT_MAX) m_cnt++;
                end
            end else begin
                col = cur[0];
                idx = (cur >> 1) & 7;
                if (idx < (col ? COLS : ROWS)) begin
                    m_apply(col, idx, 1'b0);
                    m_acc++;
                    if (m_acc == SCRAMBLE_N) begin
                        m_busy = 0;
                        m_cnt  = 0;
                    end
                end
            end
            m_solved = m_busy ? 1'b0 : eq_before;
            m_lfsr   = lfsr_step(m_lfsr);
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            check("cyc_grid",       64'(grid_state), 64'(m_pack()));
            check("cyc_solved",     64'(solved),     64'(m_solved));
            check("cyc_busy",       64'(busy),       64'(m_busy));
            check("cyc_move_done",  64'(move_done),  64'(m_md));
            check("cyc_sel_error",  64'(sel_error),  64'(m_se));
            check("cyc_move_count", 64'(move_count), 64'(m_cnt));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic fire_once();
        fire = 1'b1;
        @(negedge clk);
        fire = 1'b0;
    endtask

    task automatic run_scramble(input string tag);
        int busy_cycles;
        scramble_start = 1'b1;
        fire    = 1'b1;
        sel_col = 1'b0;
        sel     = 4'b0001;
        @(negedge clk);
        scramble_start = 1'b0;
        check({tag, "_busy_start"}, 64'(busy), 64'd1);
        busy_cycles = 0;
        while (busy === 1'b1 && busy_cycles < 1000) begin
            busy_cycles++;
            @(negedge clk);
        end
        fire = 1'b0;
        check({tag, "_exit_in_budget"}, 64'(busy_cycles < 1000), 64'd1);
        check({tag, "_busy_ge16"},      64'(busy_cycles >= 16),  64'd1);
        check({tag, "_count_zero"},     64'(move_count),         64'd0);
        check({tag, "_accepted"},       64'(m_acc),              64'd16);
    endtask

    initial begin
        check("model_lfsr_step", 64'(lfsr_step('hACE1)), 64'h59C3);

        reset = 1'b0;
        repeat (2) @(negedge clk);
        check_en = 1'b1;
        check("rst_grid",       64'(grid_state), 64'd0);
        check("rst_solved",     64'(solved),     64'd1);
        check("rst_busy",       64'(busy),       64'd0);
        check("rst_move_count", 64'(move_count), 64'd0);
        check("rst_sel_error",  64'(sel_error),  64'd0);
        sel   = 4'b0010;
        reset = 1'b1;
        @(negedge clk);

        // row 1 increment
        sel_col = 1'b0; dir_dec = 1'b0;
        fire_once();
        check("row_grid_row1", 64'(grid_state[15:8]), 64'h55);
        check("row_grid_rest", 64'(grid_state & ~32'h0000FF00), 64'd0);
        check("row_move_done", 64'(move_done), 64'd1);
        check("row_count",     64'(move_count), 64'd1);
        @(negedge clk);
        check("row_solved_lag", 64'(solved), 64'd0);

        // wrap back to zero
        for (int i = 0; i < 3; i++) begin
            fire_once();
            @(negedge clk);
        end
        check("wrap_row1",   64'(grid_state[15:8]), 64'h00);
        check("wrap_solved", 64'(solved),           64'd1);
        check("wrap_count",  64'(move_count),       64'd4);

        dir_dec = 1'b1;
        fire_once();
        dir_dec = 1'b0;
        check("dec_row1", 64'(grid_state[15:8]), 64'hFF);

        // invalid select (two bits set)
        sel = 4'b0110;
        fire_once();
        check("inv_row1",      64'(grid_state[15:8]), 64'hFF);
        check("inv_sel_error", 64'(sel_error),        64'd1);
        check("inv_move_done", 64'(move_done),        64'd0);
        check("inv_count",     64'(move_count),       64'd5);

        // column 0 increment
        sel_col = 1'b1; sel = 4'b0001;
        fire_once();
        check("col_grid",  64'(grid_state), 64'h0101FC01);
        check("col_count", 64'(move_count), 64'd6);
        @(negedge clk);

        // counter saturation
        sel_col = 1'b0; sel = 4'b0001;
        fire = 1'b1;
        repeat (16400) @(negedge clk);
        fire = 1'b0;
        @(negedge clk);
        check("count_sat", 64'(move_count), 64'd16383);

        run_scramble("scr1");
        repeat (3) @(negedge clk);

        // reset on the 5th busy cycle
        scramble_start = 1'b1;
        @(negedge clk);
        scramble_start = 1'b0;
        repeat (4) @(negedge clk);
        check("mid_busy_before", 64'(busy), 64'd1);
        reset = 1'b0;
        @(negedge clk);
        check("mid_rst_grid",   64'(grid_state), 64'd0);
        check("mid_rst_busy",   64'(busy),       64'd0);
        check("mid_rst_solved", 64'(solved),     64'd1);
        reset = 1'b1;
        @(negedge clk);

        run_scramble("scr2");
        repeat (3) @(negedge clk);

        check_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
